load_response_formatter: RTL
============================

Name: load_response_formatter

Overview:
- Sits directly downstream of the load-attributes FIFO in the load/store unit.
- Pairs the FIFO head entry (funct3, byte offset, instruction ID, subunit select) with the data word returned by the selected memory subunit.
- Aligns and sign/zero-extends the word, then presents it to writeback through a single registered output with a valid/ack handshake.
- Pops the attributes FIFO exactly once per completed load.

Parameters:
- NUM_SUBUNITS, 3, number of load data sources (e.g. local mem, dcache, bus); 1..4
- ID_W, 3, width of the instruction ID carried in the attributes
- XLEN, 32, data width; fixed at 32

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- attr_valid  in  1  attributes FIFO head valid
- attr_fn3  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- attr_byte_addr  in  2  address[1:0] of the load
- attr_id  in  ID_W  instruction ID
- attr_subunit  in  2  index of the subunit that will return data
- attr_pop  out  1  pop strobe to attributes FIFO
- sub_data_valid  in  NUM_SUBUNITS  per-subunit data-return valid
- sub_data  in  NUM_SUBUNITS*XLEN  per-subunit data; subunit i at bits [i*32 +: 32]
- sub_data_ack  out  NUM_SUBUNITS  one-hot accept of returned data
- wb_valid  out  1  formatted result valid
- wb_data  out  XLEN  formatted result
- wb_id  out  ID_W  ID of the result
- wb_ack  in  1  writeback consumed result this cycle
- order_error  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst=1): wb_valid=0, order_error=0. wb_data and wb_id clear to 0. attr_pop and sub_data_ack are combinational and are 0 whenever wb_valid=0 and no accept condition holds.
- slot_free = ~wb_valid | wb_ack.
- Accept condition: accept = attr_valid & sub_data_valid[attr_subunit] & slot_free & (attr_subunit < NUM_SUBUNITS).
- On accept (all combinational in the same cycle):
  - attr_pop=1.
  - sub_data_ack = one-hot(attr_subunit).
- On accept, the output register loads at the next edge:
  - wb_valid <= 1, wb_id <= attr_id, wb_data <= fmt(word).
- Latency: 1 cycle from accept to wb_valid. Throughput: 1 load/cycle when wb_ack is held high.
- When wb_ack=1 and there is no accept: wb_valid <= 0.
- When wb_valid=1 and wb_ack=0: wb_data and wb_id hold. No accept occurs (back-pressure). sub_data_ack=0 for every subunit, and subunits must hold their data.
- fmt(word):
  - s = word >> (8*attr_byte_addr), zero-filled.
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: s unmodified. Misaligned LW/LH yield the shifted value; misalignment is trapped upstream.
  - Undefined fn3 values (011, 110, 111) are treated as LW.
- Ordering:
  - Data must return in attribute order.
  - If any sub_data_valid[i] is asserted for i != attr_subunit while attr_valid=1, or any sub_data_valid is asserted while attr_valid=0, then order_error <= 1. It is sticky until reset.
  - That data is not acked.
  - The head entry still completes normally when its own subunit returns.
- attr_subunit >= NUM_SUBUNITS: the entry never completes; order_error <= 1.
- Reset mid-operation: the output register empties immediately. Any in-flight attribute/data pairing is dropped. The FIFO is reset by the same rst.

Test Plan:
- LB, byte_addr=2, subunit 1 returns 0x12_80_34_56 -> attr_pop and sub_data_ack=3'b010 same cycle; next cycle wb_valid=1, wb_data=0xFFFFFF80, wb_id echoed.
- LHU, byte_addr=2, data 0x8001_1234 -> wb_data=0x00008001. LH with the same data -> 0xFFFF8001. LW, byte_addr=0, 0xDEADBEEF -> 0xDEADBEEF.
- Back-to-back: 4 loads with wb_ack tied 1 and data ready each cycle -> 4 consecutive wb_valid cycles, IDs 0,1,2,3 in order, 4 pops.
- Back-pressure: wb_ack=0 for 3 cycles with the next load's data valid -> wb_data/wb_id stable, attr_pop=0, sub_data_ack=0. When wb_ack rises -> pop and ack in that cycle, new result next cycle.
- Out-of-order: head expects subunit 0, subunit 2 asserts valid -> order_error=1 next cycle and stays 1, sub_data_ack=0. Subunit 0 then returns -> load completes.
- Async reset asserted while wb_valid=1 mid-cycle -> wb_valid=0 and order_error=0 immediately, without a clock edge.

Source files
------------

// File: rtl/load_response_formatter_if.sv
// rtl/load_response_formatter_if.sv - load response formatter bus bundle
//
// Purpose: groups the attributes-FIFO head, subunit data return and
// writeback handshake signals of the load response formatter.
// Ports (signals):
//   attr_valid/attr_fn3/attr_byte_addr/attr_id/attr_subunit  FIFO head entry
//   attr_pop                                                  FIFO pop strobe
//   sub_data_valid/sub_data/sub_data_ack                      subunit returns
//   wb_valid/wb_data/wb_id/wb_ack                             writeback result
//   order_error                                               sticky protocol flag
// Modports: slave = formatter side, master = surrounding LSU / bench side.
interface load_response_formatter_if #(
  parameter int NUM_SUBUNITS = 3,
  parameter int ID_W         = 3,
  parameter int XLEN         = 32
);
  logic                         attr_valid;
  logic [2:0]                   attr_fn3;
  logic [1:0]                   attr_byte_addr;
  logic [ID_W-1:0]              attr_id;
  logic [1:0]                   attr_subunit;
  logic                         attr_pop;
  logic [NUM_SUBUNITS-1:0]      sub_data_valid;
  logic [NUM_SUBUNITS*XLEN-1:0] sub_data;
  logic [NUM_SUBUNITS-1:0]      sub_data_ack;
  logic                         wb_valid;
  logic [XLEN-1:0]              wb_data;
  logic [ID_W-1:0]              wb_id;
  logic                         wb_ack;
  logic                         order_error;

  modport slave (
    input  attr_valid, attr_fn3, attr_byte_addr, attr_id, attr_subunit,
    output attr_pop,
    input  sub_data_valid, sub_data,
    output sub_data_ack,
    output wb_valid, wb_data, wb_id,
    input  wb_ack,
    output order_error
  );

  modport master (
    output attr_valid, attr_fn3, attr_byte_addr, attr_id, attr_subunit,
    input  attr_pop,
    output sub_data_valid, sub_data,
    input  sub_data_ack,
    input  wb_valid, wb_data, wb_id,
    output wb_ack,
    input  order_error
  );
endinterface

// File: rtl/load_response_formatter.sv
// rtl/load_response_formatter.sv - pairs load attributes with returned data and formats the result
//
// Purpose: takes the attributes-FIFO head entry, waits for the selected
// subunit to return its word, aligns and sign/zero-extends it and presents
// it to writeback from a single output register with a valid/ack handshake.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   load_response_formatter_if.slave (attributes, subunit data,
//         writeback handshake, sticky order_error)
module load_response_formatter #(
  parameter int NUM_SUBUNITS = 3,
  parameter int ID_W         = 3,
  parameter int XLEN         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  load_response_formatter_if.slave bus
);

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;

  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q,  wb_data_d;
  logic [ID_W-1:0] wb_id_q,    wb_id_d;
  logic            order_error_q, order_error_d;

  logic [NUM_SUBUNITS-1:0] head_onehot;
  logic                    sub_in_range;
  logic                    head_data_valid;
  logic                    slot_free;
  logic                    accept;
  logic                    stray_valid;
  logic [XLEN-1:0]         head_word;
  logic [XLEN-1:0]         shifted;
  logic [XLEN-1:0]         formatted;

  // Decode of the head's subunit; an out-of-range index decodes to all
  // zeros so it can never match a returning subunit and never completes.
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < NUM_SUBUNITS; i++) begin
      head_onehot[i] = (bus.attr_subunit == 2'(i));
    end
  end

  assign sub_in_range    = (int'(bus.attr_subunit) < NUM_SUBUNITS);
  assign head_data_valid = |(bus.sub_data_valid & head_onehot);
  assign slot_free       = ~wb_valid_q | bus.wb_ack;
  assign accept          = bus.attr_valid & head_data_valid & slot_free;

  // Any return that does not belong to the current head is out of order.
  always_comb begin
    if (bus.attr_valid) begin
      stray_valid = |(bus.sub_data_valid & ~head_onehot);
    end else begin
      stray_valid = |bus.sub_data_valid;
    end
  end

  always_comb begin
    head_word = '0;
    for (int i = 0; i < NUM_SUBUNITS; i++) begin
      if (head_onehot[i]) begin
        head_word = bus.sub_data[i*XLEN +: XLEN];
      end
    end
  end

  // Byte lane alignment: shift the addressed byte down to bit 0.
  assign shifted = head_word >> {bus.attr_byte_addr, 3'b000};

  always_comb begin
    case (bus.attr_fn3)
      FN3_LB:  formatted = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      FN3_LBU: formatted = {{(XLEN-8){1'b0}}, shifted[7:0]};
      FN3_LH:  formatted = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      FN3_LHU: formatted = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: formatted = shifted;  // LW and the undefined encodings
    endcase
  end

  always_comb begin
    wb_valid_d    = wb_valid_q;
    wb_data_d     = wb_data_q;
    wb_id_d       = wb_id_q;
    order_error_d = order_error_q;

    if (accept) begin
      wb_valid_d = 1'b1;
      wb_data_d  = formatted;
      wb_id_d    = bus.attr_id;
    end else if (bus.wb_ack) begin
      wb_valid_d = 1'b0;
    end

    if (stray_valid || (bus.attr_valid && !sub_in_range)) begin
      order_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_id_q       <= '0;
      order_error_q <= 1'b0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_id_q       <= wb_id_d;
      order_error_q <= order_error_d;
    end
  end

  assign bus.attr_pop     = accept;
  assign bus.sub_data_ack = accept ? head_onehot : '0;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_id        = wb_id_q;
  assign bus.order_error  = order_error_q;

endmodule
